// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage decode fields in, stage valids/enables/bypass selects out
interface pipe_ctrl_if #(parameter int NREG_W = 5, parameter int CNT_W = 32);
  logic [NREG_W-1:0] id_rj, id_rk, id_rd;
  logic id_src1_from_ref, id_src2_from_ref, id_src2_is_rd, id_ref_we, id_res_from_dram, id_br_taken, mem_data_ok;
  logic pc_we, br_redirect, if_valid, id_valid, ex_valid, mem_valid, wb_valid;
  logic id_to_ex_en, ex_to_mem_en, mem_to_wb_en, if_to_id_en;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rj, id_rk, id_rd, id_src1_from_ref, id_src2_from_ref, id_src2_is_rd, id_ref_we, id_res_from_dram, id_br_taken, mem_data_ok,
    input pc_we, br_redirect, if_valid, id_valid, ex_valid, mem_valid, wb_valid, id_to_ex_en, ex_to_mem_en, mem_to_wb_en, if_to_id_en, fwd_sel1, fwd_sel2, stall_cnt
  );
  modport slave (
    input id_rj, id_rk, id_rd, id_src1_from_ref, id_src2_from_ref, id_src2_is_rd, id_ref_we, id_res_from_dram, id_br_taken, mem_data_ok,
    output pc_we, br_redirect, if_valid, id_valid, ex_valid, mem_valid, wb_valid, id_to_ex_en, ex_to_mem_en, mem_to_wb_en, if_to_id_en, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage valid/allowin chain, dest shadow, ID bypass selects and interlocks
module pipe_ctrl #(
  parameter int NREG_W = 5,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  pipe_ctrl_if.slave bus
);
  logic r_if_valid, r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid;
  logic [NREG_W-1:0] r_ex_dest, r_mem_dest, r_wb_dest;
  logic r_ex_we, r_mem_we, r_wb_we, r_ex_ld, r_mem_ld;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [NREG_W-1:0] w_reg2;
  logic [1:0] w_sel1, w_sel2;
  logic w_hazard, w_id_rg, w_mem_rg, w_mem_allowin, w_ex_allowin, w_id_allowin, w_if_allowin;
  logic w_redirect, w_id_to_ex_en, w_ex_to_mem_en, w_mem_to_wb_en;
  function automatic logic [1:0] src_sel(input logic u, input logic [NREG_W-1:0] r);
    return (!u || r == '0) ? 2'd0 :
           (r_ex_valid && r_ex_we && r_ex_dest == r) ? 2'd1 :
           (r_mem_valid && r_mem_we && r_mem_dest == r) ? 2'd2 :
           (r_wb_valid && r_wb_we && r_wb_dest == r) ? 2'd3 : 2'd0;
  endfunction
  // youngest matching producer wins; a load still in EX or waiting in MEM cannot supply data yet
  always_comb begin
    w_reg2 = bus.id_src2_is_rd ? bus.id_rd : bus.id_rk;
    w_sel1 = src_sel(bus.id_src1_from_ref, bus.id_rj);
    w_sel2 = src_sel(bus.id_src2_from_ref | bus.id_src2_is_rd, w_reg2);
    w_hazard = (w_sel1 == 2'd1 && r_ex_ld) || (w_sel1 == 2'd2 && r_mem_ld && !bus.mem_data_ok) ||
               (w_sel2 == 2'd1 && r_ex_ld) || (w_sel2 == 2'd2 && r_mem_ld && !bus.mem_data_ok);
    w_id_rg = ~w_hazard;
    w_mem_rg = ~r_mem_ld | bus.mem_data_ok;
    w_mem_allowin = ~r_mem_valid | w_mem_rg;
    w_ex_allowin = ~r_ex_valid | w_mem_allowin;
    w_id_allowin = ~r_id_valid | (w_id_rg & w_ex_allowin);
    w_if_allowin = ~r_if_valid | w_id_allowin;
    w_redirect = r_id_valid & w_id_rg & bus.id_br_taken;
    w_id_to_ex_en = r_id_valid & w_id_rg & w_ex_allowin;
    w_ex_to_mem_en = r_ex_valid & w_mem_allowin;
    w_mem_to_wb_en = r_mem_valid & w_mem_rg;
  end
  // advance valids on allowin, shift dest shadow with the enables, count ID stall cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_if_valid, r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid} <= '0;
      {r_ex_dest, r_ex_we, r_ex_ld, r_mem_dest, r_mem_we, r_mem_ld, r_wb_dest, r_wb_we} <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_if_valid <= 1'b1;
      if (w_id_allowin) r_id_valid <= r_if_valid & ~w_redirect;
      if (w_ex_allowin) r_ex_valid <= r_id_valid & w_id_rg;
      if (w_mem_allowin) r_mem_valid <= r_ex_valid;
      r_wb_valid <= w_mem_to_wb_en;
      if (w_id_to_ex_en) {r_ex_dest, r_ex_we, r_ex_ld} <= {bus.id_rd, bus.id_ref_we & (bus.id_rd != '0), bus.id_res_from_dram};
      if (w_ex_to_mem_en) {r_mem_dest, r_mem_we, r_mem_ld} <= {r_ex_dest, r_ex_we, r_ex_ld};
      if (w_mem_to_wb_en) {r_wb_dest, r_wb_we} <= {r_mem_dest, r_mem_we};
      if (r_id_valid && w_hazard && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign bus.pc_we = ~reset & w_if_allowin;
  assign bus.br_redirect = ~reset & w_redirect;
  assign bus.if_to_id_en = ~reset & w_id_allowin;
  assign bus.id_to_ex_en = ~reset & w_id_to_ex_en;
  assign bus.ex_to_mem_en = ~reset & w_ex_to_mem_en;
  assign bus.mem_to_wb_en = ~reset & w_mem_to_wb_en;
  assign bus.fwd_sel1 = reset ? 2'd0 : w_sel1;
  assign bus.fwd_sel2 = reset ? 2'd0 : w_sel2;
  assign bus.if_valid = r_if_valid;
  assign bus.id_valid = r_id_valid;
  assign bus.ex_valid = r_ex_valid;
  assign bus.mem_valid = r_mem_valid;
  assign bus.wb_valid = r_wb_valid;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed pipeline scenarios with hand-computed stage/bypass/stall expectations
module tb_pipe_ctrl;
  logic clk, reset;
  int n_vec, n_err;
  pipe_ctrl_if #(.NREG_W(5), .CNT_W(32)) bus();
  pipe_ctrl #(.NREG_W(5), .CNT_W(32)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic s2, input logic we, input logic ld, input logic br);
    bus.id_rj = rj;
    bus.id_rk = rk;
    bus.id_rd = rd;
    bus.id_src1_from_ref = u1;
    bus.id_src2_from_ref = u2;
    bus.id_src2_is_rd = s2;
    bus.id_ref_we = we;
    bus.id_res_from_dram = ld;
    bus.id_br_taken = br;
    #1;
  endtask
  task automatic ind();
    put(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic ld4();
    put(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.mem_data_ok = 1'b1;
    put(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_we", bus.pc_we, 0);
    chk("rst_valids", {bus.if_valid, bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid}, 0);
    chk("rst_ens", {bus.if_to_id_en, bus.id_to_ex_en, bus.ex_to_mem_en, bus.mem_to_wb_en}, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_fwd", {bus.fwd_sel1, bus.fwd_sel2}, 0);
    reset = 1'b0;
    ind();
    chk("c0_pc_we", bus.pc_we, 1);
    step();
    chk("c1_if_id_valid", {bus.if_valid, bus.id_valid}, 2'b10);
    repeat (4) step();
    chk("c5_valids", {bus.if_valid, bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid}, 5'b11111);
    chk("c5_ens", {bus.pc_we, bus.if_to_id_en, bus.id_to_ex_en, bus.ex_to_mem_en, bus.mem_to_wb_en}, 5'b11111);
    chk("c5_stall_cnt", bus.stall_cnt, 0);
    chk("c5_fwd", {bus.fwd_sel1, bus.fwd_sel2}, 0);
    repeat (2) step();
    chk("c7_stall_cnt", bus.stall_cnt, 0);
    step(); put(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); put(5'd4, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fwd_ex_sel1", bus.fwd_sel1, 1);
    chk("fwd_ex_sel2", bus.fwd_sel2, 1);
    chk("fwd_ex_nostall", bus.id_to_ex_en, 1);
    step(); put(5'd4, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fwd_mem_sel1", bus.fwd_sel1, 2);
    chk("fwd_r0_sel2", bus.fwd_sel2, 0);
    step(); put(5'd0, 5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fwd_wb_sel2", bus.fwd_sel2, 3);
    chk("fwd_r0_sel1", bus.fwd_sel1, 0);
    step(); put(5'd7, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fwd_mix_sel1", bus.fwd_sel1, 1);
    chk("fwd_mix_sel2", bus.fwd_sel2, 3);
    step(); put(5'd6, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fwd_prio_ex_over_wb", bus.fwd_sel1, 1);
    chk("fwd_prio_mem", bus.fwd_sel2, 2);
    step(); put(5'd0, 5'd6, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fwd_unused_src1", bus.fwd_sel1, 0);
    chk("fwd_after_r0_write", bus.fwd_sel2, 2);
    repeat (3) begin step(); ind(); end
    step(); ld4();
    step(); put(5'd4, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_sel1_ex", bus.fwd_sel1, 1);
    chk("lu_stall_en", {bus.pc_we, bus.if_to_id_en, bus.id_to_ex_en}, 0);
    chk("lu_cnt0", bus.stall_cnt, 0);
    step();
    chk("lu_ex_bubble", bus.ex_valid, 0);
    chk("lu_sel1_mem", bus.fwd_sel1, 2);
    chk("lu_release", bus.id_to_ex_en, 1);
    chk("lu_cnt1", bus.stall_cnt, 1);
    step(); ind();
    chk("lu_ex_refill", bus.ex_valid, 1);
    chk("lu_cnt_hold", bus.stall_cnt, 1);
    repeat (3) begin step(); ind(); end
    step(); ld4();
    step(); put(5'd4, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_data_ok = 1'b0;
    #1;
    chk("slow_c1_stall", bus.id_to_ex_en, 0);
    chk("slow_c1_nonload_moves", bus.mem_to_wb_en, 1);
    step();
    chk("slow_c2_wb_en", bus.mem_to_wb_en, 0);
    chk("slow_c2_stall", {bus.pc_we, bus.id_to_ex_en}, 0);
    chk("slow_c2_sel1", bus.fwd_sel1, 2);
    chk("slow_c2_cnt", bus.stall_cnt, 2);
    step();
    chk("slow_c3_wb_en", bus.mem_to_wb_en, 0);
    chk("slow_c3_cnt", bus.stall_cnt, 3);
    step();
    chk("slow_c4_wb_en", bus.mem_to_wb_en, 0);
    chk("slow_c4_cnt", bus.stall_cnt, 4);
    step();
    bus.mem_data_ok = 1'b1;
    #1;
    chk("slow_c5_wb_en", bus.mem_to_wb_en, 1);
    chk("slow_c5_release", bus.id_to_ex_en, 1);
    chk("slow_c5_cnt", bus.stall_cnt, 5);
    step(); ind();
    chk("slow_wb_valid", bus.wb_valid, 1);
    chk("slow_cnt_hold", bus.stall_cnt, 5);
    repeat (2) begin step(); ind(); end
    step(); put(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_redirect", bus.br_redirect, 1);
    chk("br_pc_we", bus.pc_we, 1);
    chk("br_issue", bus.id_to_ex_en, 1);
    step(); put(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_id_cancel", bus.id_valid, 0);
    chk("br_no_redirect_invalid", bus.br_redirect, 0);
    chk("br_if_to_id", bus.if_to_id_en, 1);
    chk("br_in_ex", bus.ex_valid, 1);
    step(); ind();
    chk("br_target_in_id", bus.id_valid, 1);
    chk("br_ex_bubble", bus.ex_valid, 0);
    repeat (2) begin step(); ind(); end
    step(); ld4();
    step(); put(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("brld_no_redirect", bus.br_redirect, 0);
    chk("brld_sel2_rd", bus.fwd_sel2, 1);
    chk("brld_stall", bus.id_to_ex_en, 0);
    step();
    chk("brld_redirect", bus.br_redirect, 1);
    chk("brld_sel2_mem", bus.fwd_sel2, 2);
    chk("brld_cnt", bus.stall_cnt, 6);
    step(); ind();
    chk("brld_id_cancel", bus.id_valid, 0);
    repeat (2) begin step(); ind(); end
    step(); ld4();
    step(); put(5'd4, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_data_ok = 1'b0;
    #1;
    step();
    chk("mrst_mem_stalled", bus.mem_to_wb_en, 0);
    reset = 1'b1;
    #1;
    chk("mrst_pc_we", bus.pc_we, 0);
    chk("mrst_ens", {bus.if_to_id_en, bus.id_to_ex_en, bus.ex_to_mem_en, bus.mem_to_wb_en, bus.br_redirect}, 0);
    chk("mrst_fwd_in_reset", {bus.fwd_sel1, bus.fwd_sel2}, 0);
    step();
    reset = 1'b0;
    #1;
    chk("mrst_valids", {bus.if_valid, bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid}, 0);
    chk("mrst_cnt", bus.stall_cnt, 0);
    chk("mrst_fwd", {bus.fwd_sel1, bus.fwd_sel2}, 0);
    bus.mem_data_ok = 1'b1;
    step();
    chk("mrst_if_restart", {bus.if_valid, bus.id_valid}, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage LoongArch core (IF/ID/EX/MEM/WB). It owns the per-stage valid bits and the allowin/ready_go handshake chain. It keeps a shadow of each in-flight instruction's destination register and drives the ID-stage operand bypass selects. It inserts load-use and slow-memory interlocks, and cancels the wrong-path IF instruction when ID resolves a taken branch.

## Interface
Parameters:
- NREG_W, 5, register-index width
- CNT_W, 32, stall performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rj  in  5  source register 1 index of instruction in ID
- id_rk  in  5  source register 2 index (R-type)
- id_rd  in  5  destination index (already forced to 1 for bl)
- id_src1_from_ref  in  1  ID reads rj
- id_src2_from_ref  in  1  ID reads rk
- id_src2_is_rd  in  1  ID reads rd as second source (beq/bne/st.w)
- id_ref_we  in  1  ID writes rd
- id_res_from_dram  in  1  ID is a load
- id_br_taken  in  1  ID branch/jump resolved taken (uses bypassed operands)
- mem_data_ok  in  1  data RAM has returned load data for the MEM-stage load
- pc_we  out  1  IF may load next PC (= if_allowin)
- br_redirect  out  1  PC must take id_br_target this cycle
- if_valid, id_valid, ex_valid, mem_valid, wb_valid  out  1 each  stage valid bits
- id_to_ex_en, ex_to_mem_en, mem_to_wb_en, if_to_id_en  out  1 each  pipeline-register load enables
- fwd_sel1, fwd_sel2  out  2 each  ID operand source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
- stall_cnt  out  CNT_W  cycles in which ID held a valid instruction but was not ready

## Operation
- Handshake per stage X feeding Y:
  - X_allowin = ~X_valid | (X_ready_go & Y_allowin)
  - X_to_Y_valid = X_valid & X_ready_go
  - X_valid <= W_to_X_valid when X_allowin
  - WB allowin = 1
- ready_go:
  - IF = 1, EX = 1, WB = 1
  - ID = ~hazard
  - MEM = ~(mem_is_load) | mem_data_ok
- Enables: each X_to_Y_en = X_to_Y_valid & Y_allowin. if_to_id_en = id_allowin.
- IF: if_valid = 0 in reset, 1 from the first cycle after reset deasserts, then constant 1.
- Shadow state shifts with the enables:
  - EX, MEM and WB each hold dest and we; EX and MEM also hold is_load.
  - A valid stage's we = id_ref_we & (id_rd != 0) at issue.
- Source use:
  - use1 = id_src1_from_ref, reg1 = id_rj.
  - use2 = id_src2_from_ref | id_src2_is_rd, reg2 = id_src2_is_rd ? id_rd : id_rk.
- Bypass priority per source: EX > MEM > WB > regfile. A stage matches when its valid, we, and dest == reg, and dest != 0.
- Hazard is raised when a used source's highest-priority match is either:
  - EX with ex_is_load, or
  - MEM with mem_is_load & ~mem_data_ok.
- br_redirect = id_valid & id_ready_go & id_br_taken.
  - On redirect, id_valid loads 0 (IF instruction cancelled), regardless of if_to_id_valid.
  - No redirect while ID is stalled.
- stall_cnt increments when id_valid & ~id_ready_go. It saturates at all-ones.

## Timing
- Reset: all valid bits, enables, br_redirect, fwd selects, shadow state and stall_cnt are 0. pc_we = 0 during reset.
- Reset asserted mid-operation clears everything on that edge. In-flight instructions are dropped and no enable asserts in the reset cycle.
- Bypass selects and hazard are combinational from the current shadow state and ID inputs, valid in the same cycle.
- Load-use:
  - A dependent instruction directly behind a load stalls ID for 1 cycle.
  - It is then bypassed from MEM when mem_data_ok = 1.
  - It stays stalled while the load sits in MEM with mem_data_ok = 0.
- During a stall, EX receives a bubble (ex_valid <= 0) and IF/ID hold.
- A stalled MEM stage back-pressures EX, ID and IF through allowin.
- Taken branch costs exactly 1 bubble: the IF slot.
- A dest of 0 never matches, so writes to r0 are never bypassed.
- The nop encoding's id_ref_we is already 0 and creates no dependency.

## Test plan
- Reset then free run of independent add.w: from cycle 5 after reset all five valids = 1, stall_cnt stays 0, and every enable = 1.
- add.w r4←; then add.w r5,r4,r4 next: fwd_sel1 = fwd_sel2 = 1 in that cycle, no stall. With one gap instruction sel = 2; with two gaps sel = 3.
- ld.w r4 then add.w r5,r4,r0 with mem_data_ok = 1 after 0 cycles: ID stalls exactly 1 cycle, ex_valid bubble, then fwd_sel1 = 2, stall_cnt = 1.
- Same as above with mem_data_ok held low 3 cycles: ID stalls 4 cycles total, mem_to_wb_en = 0 for 3 cycles, and stall_cnt = 4.
- beq taken with equal operands: br_redirect = 1 for one cycle, next id_valid = 0, and the following cycle's IF instruction enters ID. beq dependent on a load: br_redirect only after the stall clears.
- Assert reset for 1 cycle with a load stalled in MEM: next cycle all valids = 0, stall_cnt = 0, fwd_sel = 0.
